// File: rtl/bresenham_line_walker.sv
// bresenham_line_walker: takes one vector command (x0,y0)->(x1,y1), loads an external
// bresenhamCore with |minor|/|major| and steps it once per pixel handed downstream.
// Optional abort input is compiled in when LINE_WALK_ABORT_EN is defined.
module bresenham_line_walker #(
   parameter int unsigned CW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef LINE_WALK_ABORT_EN
   input  logic          abort,
`endif
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] cmd_x0,
   input  logic [CW-1:0] cmd_y0,
   input  logic [CW-1:0] cmd_x1,
   input  logic [CW-1:0] cmd_y1,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          pix_last,
   output logic [CW:0]   core_num,
   output logic [CW:0]   core_den,
   output logic          core_rst,
   output logic          core_en,
   input  logic          core_inc
);

   typedef enum logic [1:0] {StIdle, StSetup, StStep} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   x0_q, y0_q, x1_q, y1_q;
   logic [CW:0]     cnt_q;
   logic            sx_neg_q, sy_neg_q, xmaj_q;

   logic [CW:0]     dx, dy, adx, ady;
   logic            xmaj, fire, abort_hit;

`ifdef LINE_WALK_ABORT_EN
   assign abort_hit = abort & (state_q != StIdle);
`else
   assign abort_hit = 1'b0;
`endif

   // Signed deltas and magnitudes of the latched command; only consumed in SETUP.
   always_comb begin
      dx   = {1'b0, x1_q} - {1'b0, x0_q};
      dy   = {1'b0, y1_q} - {1'b0, y0_q};
      adx  = dx[CW] ? (~dx + 1'b1) : dx;
      ady  = dy[CW] ? (~dy + 1'b1) : dy;
      xmaj = (adx >= ady);
   end

   function automatic logic [CW-1:0] step(input logic [CW-1:0] v, input logic neg);
      return neg ? v - 1'b1 : v + 1'b1;
   endfunction

   // Handshake and core control outputs decoded from state.
   always_comb begin
      cmd_ready = (state_q == StIdle);
      pix_valid = (state_q == StStep);
      pix_last  = (state_q == StStep) && (cnt_q == '0);
      core_rst  = (state_q != StStep);
      fire      = pix_valid & pix_ready;
      // Aborted beats must not advance the core.
      core_en   = fire & ~pix_last & ~abort_hit;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_valid) state_d = StSetup;
         StSetup: state_d = StStep;
         StStep:  if (fire && pix_last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort_hit) state_d = StIdle;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Command latch, setup loads and per-pixel stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         pix_x    <= '0;
         pix_y    <= '0;
         core_num <= '0;
         core_den <= '0;
         cnt_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
         xmaj_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  x0_q <= cmd_x0;
                  y0_q <= cmd_y0;
                  x1_q <= cmd_x1;
                  y1_q <= cmd_y1;
               end
            end
            StSetup: begin
               pix_x    <= x0_q;
               pix_y    <= y0_q;
               core_num <= xmaj ? ady : adx;
               core_den <= xmaj ? adx : ady;
               cnt_q    <= xmaj ? adx : ady;
               sx_neg_q <= dx[CW];
               sy_neg_q <= dy[CW];
               xmaj_q   <= xmaj;
            end
            StStep: begin
               if (core_en) begin
                  // Major axis always advances; minor only when the core carries.
                  if (xmaj_q) begin
                     pix_x <= step(pix_x, sx_neg_q);
                     if (core_inc) pix_y <= step(pix_y, sy_neg_q);
                  end else begin
                     pix_y <= step(pix_y, sy_neg_q);
                     if (core_inc) pix_x <= step(pix_x, sx_neg_q);
                  end
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bresenham_line_walker.sv
// Scoreboard bench for bresenham_line_walker with a behavioural bresenhamCore stand-in.
module tb_bresenham_line_walker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [11:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [11:0] pix_x, pix_y;
   logic        pix_last;
   logic [12:0] core_num, core_den;
   logic        core_rst, core_en, core_inc;
   logic        abort = 1'b0;

   int checks = 0;
   int errors = 0;
   int popped = 0;
   int ready_mode = 0;
   int ready_phase = 0;

   typedef struct {
      int x;
      int y;
      bit last;
      int num;
      int den;
   } pix_t;
   pix_t exp_q[$];

   always #5 clk = ~clk;

   bresenham_line_walker #(.CW(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef LINE_WALK_ABORT_EN
      .abort     (abort),
`endif
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x0    (cmd_x0),
      .cmd_y0    (cmd_y0),
      .cmd_x1    (cmd_x1),
      .cmd_y1    (cmd_y1),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_last  (pix_last),
      .core_num  (core_num),
      .core_den  (core_den),
      .core_rst  (core_rst),
      .core_en   (core_en),
      .core_inc  (core_inc)
   );

   // Core stand-in: error accumulator that carries when acc+num reaches den.
   logic [13:0] acc;
   assign core_inc = core_en && ((int'(acc) + int'(core_num)) >= int'(core_den));
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || core_rst) acc <= '0;
      else if (core_en) begin
         if (core_inc) acc <= 14'(int'(acc) + int'(core_num) - int'(core_den));
         else          acc <= 14'(int'(acc) + int'(core_num));
      end
   end

   // Downstream ready pattern.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: pix_ready = 1'b1;
         1: begin
            pix_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
            ready_phase++;
         end
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: pixel k lies at major = start + s*k, minor = start + s*floor(k*N/M).
   function automatic void push_line(input int x0, input int y0, input int x1, input int y1);
      int dx, dy, adx, ady, m, n, sx, sy, j;
      bit xm;
      pix_t p;
      dx  = x1 - x0;
      dy  = y1 - y0;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      xm  = (adx >= ady);
      m   = xm ? adx : ady;
      n   = xm ? ady : adx;
      sx  = (dx < 0) ? -1 : 1;
      sy  = (dy < 0) ? -1 : 1;
      for (int k = 0; k <= m; k++) begin
         j      = (m == 0) ? 0 : (k * n) / m;
         p.x    = xm ? x0 + sx * k : x0 + sx * j;
         p.y    = xm ? y0 + sy * j : y0 + sy * k;
         p.last = (k == m);
         p.num  = n;
         p.den  = m;
         exp_q.push_back(p);
      end
   endfunction

   // Monitor: pops on every fired beat and checks protocol invariants.
   logic [11:0] hx, hy;
   logic        hl;
   bit          hold = 0;
   bit          last_fired = 0;
   always @(negedge clk) begin
      pix_t e;
      if (!rst_n) begin
         hold = 0;
         last_fired = 0;
      end else begin
         if (last_fired) begin
            chk("ready_after_last", int'(cmd_ready), 1);
            last_fired = 0;
         end
         chk("core_en", int'(core_en), int'(pix_valid && pix_ready && !pix_last && !abort));
         if (pix_valid) chk("busy_cmd_ready", int'(cmd_ready), 0);
         if (hold) begin
            checks++;
            if (!pix_valid || pix_x != hx || pix_y != hy || pix_last != hl) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b (%0d,%0d) l=%0b expected v=1 (%0d,%0d) l=%0b",
                        pix_valid, pix_x, pix_y, pix_last, hx, hy, hl);
            end
         end
         hold = pix_valid && !pix_ready && !abort;
         hx = pix_x;
         hy = pix_y;
         hl = pix_last;
         if (pix_valid && pix_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
            end else begin
               e = exp_q.pop_front();
               if (int'(pix_x) != e.x || int'(pix_y) != e.y || pix_last != e.last ||
                   int'(core_num) != e.num || int'(core_den) != e.den) begin
                  errors++;
                  $display("FAIL pixel: got (%0d,%0d) l=%0b n=%0d d=%0d expected (%0d,%0d) l=%0b n=%0d d=%0d",
                           pix_x, pix_y, pix_last, core_num, core_den,
                           e.x, e.y, e.last, e.num, e.den);
               end
            end
            popped++;
            if (pix_last && !abort) last_fired = 1;
         end
      end
   end

   task automatic send(input int x0, input int y0, input int x1, input int y1);
      int n;
      int m;
      m = ((x1 > x0) ? x1 - x0 : x0 - x1);
      n = ((y1 > y0) ? y1 - y0 : y0 - y1);
      if (n > m) m = n;
      push_line(x0, y0, x1, y1);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_x0 = 12'(x0); cmd_y0 = 12'(y0); cmd_x1 = 12'(x1); cmd_y1 = 12'(y1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready && n < 20000);
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         exp_q.delete();
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk) chk("latency_setup", int'(pix_valid), 0);
      @(negedge clk) chk("latency_first", int'(pix_valid), 1);
      // Junk command while busy must be ignored.
      if (m >= 3) begin
         @(posedge clk); #1;
         cmd_valid = 1'b1;
         cmd_x0 = 12'd99; cmd_y0 = 12'd99; cmd_x1 = 12'd1; cmd_y1 = 12'd1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || !cmd_ready) && n < 20000);
      if (exp_q.size() != 0 || !cmd_ready) begin
         chk("line_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic wait_pops(input int base, input int cnt);
      int n;
      n = 0;
      while (popped < base + cnt && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (popped < base + cnt) chk("pop_timeout", popped - base, cnt);
   endtask

   function automatic int clampc(input int v);
      return (v < 0) ? 0 : (v > 4095) ? 4095 : v;
   endfunction

   initial begin
      int base, x0, y0;
      #3;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_pix_last", int'(pix_last), 0);
      chk("rst_core_en", int'(core_en), 0);
      chk("rst_core_rst", int'(core_rst), 1);
      chk("rst_pix_xy", int'({pix_x, pix_y}), 0);
      chk("rst_core_numden", int'({core_num, core_den}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      ready_mode = 0;
      send(0, 0, 5, 2);    wait_done();
      send(7, 7, 7, 7);    wait_done();
      send(10, 3, 2, 3);   wait_done();
      send(0, 0, 4, 4);    wait_done();
      ready_mode = 1;
      ready_phase = 0;
      send(0, 0, 3, 9);    wait_done();

      ready_mode = 2;
      for (int i = 0; i < 30; i++) begin
         x0 = $urandom_range(0, 4095);
         y0 = $urandom_range(0, 4095);
         send(x0, y0, clampc(x0 + $urandom_range(0, 80) - 40),
              clampc(y0 + $urandom_range(0, 80) - 40));
         wait_done();
      end
      send(0, 4095, 4095, 0);  wait_done();
      send(4095, 0, 1000, 4095); wait_done();

      // Reset mid-line abandons it.
      ready_mode = 0;
      base = popped;
      send(0, 0, 20, 1);
      wait_pops(base, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_pix_valid", int'(pix_valid), 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 1);
      chk("midrst_core_rst", int'(core_rst), 1);
      chk("midrst_pix_last", int'(pix_last), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(1, 1, 2, 1);    wait_done();

`ifdef LINE_WALK_ABORT_EN
      base = popped;
      send(0, 0, 20, 1);
      wait_pops(base, 3);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_pix_valid", int'(pix_valid), 0);
      chk("abort_cmd_ready", int'(cmd_ready), 1);
      chk("abort_core_rst", int'(core_rst), 1);
      exp_q.delete();
      send(1, 1, 2, 1);    wait_done();
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
